// File: rtl/im_boot_ram_pkg.sv
// Shared types and boot image for the boot-loaded instruction memory.
// Boot image and default NOP live here so the ROM and top agree on them.
package im_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int              DATA_W_DEF     = 8;
  localparam int              BOOT_IMAGE_LEN = 6;
  localparam logic [DATA_W_DEF-1:0] NOP_CODE_DEF = 8'h00;

  localparam logic [DATA_W_DEF-1:0] BOOT_IMAGE [BOOT_IMAGE_LEN] = '{
    8'h13, 8'h52, 8'h6B, 8'hC5, 8'h29, 8'h6D
  };

endpackage

// File: rtl/im_boot_ram_if.sv
// Fetch and program-load signals between PC/loader (master) and the memory (slave).
// Fetch is request/valid with one-cycle latency; no backpressure on either side.
interface im_boot_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic [DATA_W-1:0] inst_code;
  logic              inst_valid;
  logic              addr_fault;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  modport master (
    output pc, fetch_req, wr_en, wr_addr, wr_data,
    input  inst_code, inst_valid, addr_fault, ready, wr_err
  );

  modport slave (
    input  pc, fetch_req, wr_en, wr_addr, wr_data,
    output inst_code, inst_valid, addr_fault, ready, wr_err
  );

endinterface

// File: rtl/im_boot_ram_rom.sv
// Boot image lookup: index -> boot word, NOP_CODE past the image end.
// Purely combinational, zero latency, no backpressure.
module im_boot_rom
  import im_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                BOOT_LEN = 6,
  parameter logic [DATA_W-1:0] NOP_CODE = DATA_W'(NOP_CODE_DEF)
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] word
);

  // Walking the package array keeps indexing in bounds whatever BOOT_LEN is.
  always_comb begin
    word = NOP_CODE;
    for (int i = 0; i < BOOT_IMAGE_LEN; i++) begin
      if (i < BOOT_LEN && int'(idx) == i) begin
        word = DATA_W'(BOOT_IMAGE[i]);
      end
    end
  end

endmodule

// File: rtl/im_boot_ram.sv
// Instruction memory with boot-image init and run-time program load (IM_BOOT_WP_EN write-protects boot words).
// Fetch latency 1 cycle (registered); fetches and writes are ignored/rejected until ready.
module im_boot_ram
  import im_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 8,
  parameter int                BOOT_LEN = 6,
  parameter logic [DATA_W-1:0] NOP_CODE = DATA_W'(NOP_CODE_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  im_boot_ram_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] boot_word;
  logic              pc_in_range;
  logic              wr_in_range;
  logic              wr_protected;
  logic              fetch_go;
  logic              wr_reject;

  logic [DATA_W-1:0] inst_code_q;
  logic              inst_valid_q;
  logic              addr_fault_q;
  logic              wr_err_q;

  im_boot_rom #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BOOT_LEN (BOOT_LEN),
    .NOP_CODE (NOP_CODE)
  ) u_boot_rom (
    .idx  (init_ptr_q),
    .word (boot_word)
  );

  // Full-width compares: an out-of-range pc must never alias into the array.
  assign pc_in_range = {1'b0, bus.pc}      < DEPTH_X;
  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_X;

`ifdef IM_BOOT_WP_EN
  assign wr_protected = {1'b0, bus.wr_addr} < (ADDR_W + 1)'(BOOT_LEN);
`else
  assign wr_protected = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = init_ptr_q;
    mem_wdata  = boot_word;
    fetch_go   = 1'b0;
    wr_reject  = 1'b0;

    case (state_q)
      INIT: begin
        // The init copy bypasses write protection on purpose.
        mem_we     = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        wr_reject  = bus.wr_en;
        if (init_ptr_q == LAST_IDX) begin
          state_d    = RUN;
          init_ptr_d = '0;
        end
      end
      RUN: begin
        fetch_go = bus.fetch_req;
        if (bus.wr_en) begin
          if (wr_in_range && !wr_protected) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
          end else begin
            wr_reject = 1'b1;
          end
        end
      end
      default: begin
        state_d    = INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  // Array has no reset; INIT rewrites every location before it is readable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_code_q  <= '0;
      inst_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      inst_valid_q <= fetch_go;
      addr_fault_q <= fetch_go && !pc_in_range;
      wr_err_q     <= wr_reject;
      if (fetch_go) begin
        inst_code_q <= pc_in_range ? mem[bus.pc[IDX_W-1:0]] : NOP_CODE;
      end
    end
  end

  assign bus.inst_code  = inst_code_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.addr_fault = addr_fault_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.ready      = (state_q == RUN);

endmodule

// File: tb/tb_im_boot_ram.sv
// Directed bench for im_boot_ram: init sequencing, fetch, faults, collisions, mid-run reset.
module tb_im_boot_ram;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  im_boot_ram_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  im_boot_ram #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .DEPTH    (8),
    .BOOT_LEN (6),
    .NOP_CODE (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_boot [8] = '{8'h13, 8'h52, 8'h6B, 8'hC5, 8'h29, 8'h6D, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [7:0] a, input logic [7:0] code,
                           input logic fault);
    bus.pc        = a;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    chk({tag, "_valid"}, bus.inst_valid, 1);
    chk({tag, "_code"},  bus.inst_code,  code);
    chk({tag, "_fault"}, bus.addr_fault, fault);
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    bus.pc        = '0;
    bus.fetch_req = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    #2;
    chk("rst_ready", bus.ready,      0);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_fault", bus.addr_fault, 0);
    chk("rst_wrerr", bus.wr_err,     0);
    chk("rst_code",  bus.inst_code,  0);
    tick();
    tick();

    // Release reset, request fetches throughout init, one write at edge 3.
    @(negedge clk);
    reset         = 1'b1;
    bus.pc        = 8'h00;
    bus.fetch_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'h01;
        bus.wr_data = 8'hAA;
      end
      tick();
      bus.wr_en = 1'b0;
      chk($sformatf("init_valid_e%0d", k), bus.inst_valid, 0);
      chk($sformatf("init_ready_e%0d", k), bus.ready, (k == 8) ? 1 : 0);
      if (k == 3) chk("init_wrerr_e3", bus.wr_err, 1);
      if (k == 4) chk("init_wrerr_e4", bus.wr_err, 0);
    end
    bus.fetch_req = 1'b0;

    // Back-to-back fetch of the whole array.
    for (int i = 0; i < 8; i++) begin
      fetch_chk($sformatf("boot%0d", i), 8'(i), exp_boot[i], 1'b0);
    end
    fetch_chk("boot5b", 8'h05, 8'h6D, 1'b0);
    tick();
    chk("idle_valid", bus.inst_valid, 0);
    chk("idle_fault", bus.addr_fault, 0);
    chk("idle_hold",  bus.inst_code,  8'h6D);

    // Out of range fetches and writes.
    fetch_chk("oor08", 8'h08, 8'h00, 1'b1);
    fetch_chk("oor88", 8'h88, 8'h00, 1'b1);
    write(8'hFF, 8'h55);
    chk("oor_wrerr", bus.wr_err, 1);
    tick();
    chk("oor_wrerr_clr", bus.wr_err, 0);
    fetch_chk("oor_intact7", 8'h07, 8'h00, 1'b0);
    fetch_chk("oor_intact0", 8'h00, 8'h13, 1'b0);

    // Same-cycle fetch and write to address 6.
    bus.pc        = 8'h06;
    bus.fetch_req = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 8'h06;
    bus.wr_data   = 8'h6A;
    tick();
    bus.fetch_req = 1'b0;
    bus.wr_en     = 1'b0;
    chk("coll_valid", bus.inst_valid, 1);
    chk("coll_old",   bus.inst_code,  8'h00);
    chk("coll_wrerr", bus.wr_err,     0);
    fetch_chk("coll_new", 8'h06, 8'h6A, 1'b0);

    // Writes into and past the boot region.
    write(8'h03, 8'h77);
`ifdef IM_BOOT_WP_EN
    chk("wp3_wrerr", bus.wr_err, 1);
    fetch_chk("wp3_read", 8'h03, 8'hC5, 1'b0);
`else
    chk("wp3_wrerr", bus.wr_err, 0);
    fetch_chk("wp3_read", 8'h03, 8'h77, 1'b0);
`endif
    write(8'h07, 8'h99);
    chk("wr7_wrerr", bus.wr_err, 0);
    fetch_chk("wr7_read", 8'h07, 8'h99, 1'b0);

    // Mid-run reset: program-loaded data is overwritten, in-flight fetch dropped.
    write(8'h02, 8'h6A);
    fetch_chk("pre_rst2", 8'h02, 8'h6A, 1'b0);
    bus.pc        = 8'h02;
    bus.fetch_req = 1'b1;
    reset         = 1'b0;
    #1;
    chk("mrst_valid", bus.inst_valid, 0);
    chk("mrst_ready", bus.ready,      0);
    chk("mrst_code",  bus.inst_code,  0);
    tick();
    chk("mrst_valid_e", bus.inst_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      tick();
      n++;
      chk($sformatf("reinit_valid%0d", n), bus.inst_valid, 0);
    end
    chk("reinit_edges", n, 8);
    tick();
    bus.fetch_req = 1'b0;
    chk("reinit_valid", bus.inst_valid, 1);
    chk("reinit_code2", bus.inst_code,  8'h6B);
    fetch_chk("reinit3", 8'h03, 8'hC5, 1'b0);
    fetch_chk("reinit6", 8'h06, 8'h00, 1'b0);
    fetch_chk("reinit7", 8'h07, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im_boot_ram.md
Name: im_boot_ram

Overview:
Parametrised instruction memory, successor to the fixed 8-entry byte-wide IM. Width and depth are parametrised, and the contents are writable at run time through a program-load port. Fetches are registered with a request/valid handshake and out-of-range fault flagging. After reset release, an init FSM copies a built-in boot image into the array before it accepts fetches. The block sits between the PC register and the instruction decoder.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, PC / address width in bits.
- DEPTH, 8, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- BOOT_LEN, 6, number of boot-image words; must satisfy BOOT_LEN <= DEPTH.
- NOP_CODE, 8'h00, word returned on a faulting fetch and written to every non-boot location during init.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- pc, in, ADDR_W, fetch address.
- fetch_req, in, 1, fetch request.
- inst_code, out, DATA_W, fetched instruction (registered).
- inst_valid, out, 1, one-cycle pulse; inst_code is valid while it is high.
- addr_fault, out, 1, qualifies inst_valid; asserted when pc >= DEPTH.
- ready, out, 1, high once init has completed.
- wr_en, in, 1, program-load write strobe.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- wr_err, out, 1, one-cycle pulse when a write is rejected.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-low.
- While reset = 0, the following hold immediately:
  - state = INIT, init_ptr = 0;
  - inst_code = 0, inst_valid = 0, addr_fault = 0, ready = 0, wr_err = 0.
  - Array contents are don't-care until INIT rewrites them.
- States are INIT and RUN.
- INIT:
  - Each clock writes mem[init_ptr] = BOOT[init_ptr] if init_ptr < BOOT_LEN, otherwise NOP_CODE. init_ptr then increments.
  - After the write of location DEPTH-1, state moves to RUN and ready rises.
  - ready is high on the DEPTH-th rising edge after reset release.
- Boot image, locations 0..5: 13, 52, 6B, C5, 29, 6D (hex).
- In INIT:
  - fetch_req is ignored: inst_valid stays 0.
  - wr_en is rejected: no array write, and wr_err pulses the next cycle.
- RUN, fetch:
  - fetch_req = 1 at edge N gives inst_valid = 1 for the cycle after edge N (1-cycle latency).
  - If pc < DEPTH: inst_code = mem[pc], addr_fault = 0.
  - Otherwise: inst_code = NOP_CODE, addr_fault = 1.
  - fetch_req = 0: inst_valid = 0 and addr_fault = 0; inst_code holds its last value.
  - Back-to-back requests give one result per cycle.
- RUN, write:
  - wr_en = 1 with wr_addr < DEPTH writes mem[wr_addr] = wr_data at the edge.
  - wr_en = 1 with wr_addr >= DEPTH performs no write and pulses wr_err.
- Same-cycle fetch and write to the same address: the fetch returns the old data (read-before-write). The new data is visible from the next fetch.
- pc is compared at full ADDR_W width. There is no wrap or truncation into the array.
- Reset asserted mid-operation:
  - Aborts immediately and returns to INIT.
  - Init re-runs in full, so the boot image overwrites any program-loaded data.
  - A fetch in flight is dropped; inst_valid never pulses for it.

Optional Feature:
- Macro: IM_BOOT_WP_EN.
- Defined: locations 0..BOOT_LEN-1 are write-protected in RUN. A wr_en to those locations performs no write and pulses wr_err.
- Undefined: every in-range location is writable and wr_err is raised only for out-of-range or INIT-time writes.
- The INIT copy ignores the protection in both builds.

Decomposition:
- Package im_pkg holds:
  - the state enum {INIT, RUN};
  - the BOOT_IMAGE constant array (DATA_W-wide, BOOT_LEN entries);
  - the default NOP_CODE.
- One sub-module, im_boot_rom: combinational index -> boot word. It returns NOP_CODE for an index >= BOOT_LEN and is used by the INIT sequencer.

Test Plan:
- Reset release, defaults: ready rises on edge 8. A fetch from pc = 0..7 returns 13, 52, 6B, C5, 29, 6D, 00, 00, each with inst_valid 1 cycle after its request.
- Fetch during INIT: fetch_req = 1 on edges 1-7 gives inst_valid = 0 throughout, and wr_en at edge 3 pulses wr_err.
- Out of range: fetch pc = 8'h08 gives inst_code = 00, addr_fault = 1, inst_valid = 1. A write to wr_addr = 8'hFF pulses wr_err and leaves the array unchanged.
- Collision: same cycle, fetch pc = 6 and write wr_addr = 6, wr_data = 6A. The fetch returns 00; the next fetch of pc = 6 returns 6A.
- Reset mid-run: write 6A to addr 2, assert reset for 1 cycle, then wait for ready. A fetch of pc = 2 returns 6B, and a fetch requested in the cycle reset asserted never raises inst_valid.
- IM_BOOT_WP_EN build: a write to addr 3 pulses wr_err and pc = 3 still returns C5; a write to addr 7 succeeds. Without the macro, the write to addr 3 succeeds.
